// File: rtl/boot_pkg.sv
// Shared definitions for the boot port router: magic byte default and source encodings.
package boot_pkg;

  localparam logic [7:0] MAGIC_BYTE_DEFAULT = 8'hbc;

  localparam logic [1:0] SRC_I2C = 2'd0;
  localparam logic [1:0] SRC_U0  = 2'd1;
  localparam logic [1:0] SRC_U1  = 2'd2;

  // The state encoding is the sel output encoding, so sel is the state register itself.
  typedef enum logic [1:0] {
    SEL_I2C = SRC_I2C,
    SEL_U0  = SRC_U0,
    SEL_U1  = SRC_U1
  } sel_state_e;

endpackage

// File: rtl/byte_skid_reg.sv
// One-entry valid/ready holding register with a synchronous flush that drops any pending byte.
module byte_skid_reg (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flush,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready
);

  logic       valid_q, valid_d;
  logic [7:0] data_q,  data_d;

  // Accept when empty or when the current byte leaves this cycle: full rate with out_ready high.
  assign in_ready = !valid_q || out_ready;

  // NOTE: defaults first so every path assigns valid_d/data_d and no latch is inferred.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else begin
      if (valid_q && out_ready) valid_d = 1'b0;
      if (in_valid && in_ready) begin
        valid_d = 1'b1;
        data_d  = in_data;
      end
    end
  end

  // NOTE: the data byte is reset too, because bl_in_data must read 0 while reset_n is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      // NOTE: non-blocking for all state so every flop samples pre-edge values.
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/boot_port_router.sv
// Routes one of I2C / UART0 / UART1 to the SPI bootloader: magic-byte lock-in,
// break and idle-timeout bootloader resets, registered RX stage, combinational TX return.
module boot_port_router
  import boot_pkg::*;
#(
  parameter logic [7:0]  MAGIC_BYTE     = MAGIC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 12000000,
  parameter int unsigned CNT_W          = 24
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       u0_rx_valid,
  input  logic [7:0] u0_rx_data,
  output logic       u0_rx_ready,
  input  logic       u0_rx_break,
  output logic       u0_tx_valid,
  output logic [7:0] u0_tx_data,
  input  logic       u0_tx_ready,
  output logic       u0_tx_oe,
  input  logic       u1_rx_valid,
  input  logic [7:0] u1_rx_data,
  output logic       u1_rx_ready,
  input  logic       u1_rx_break,
  output logic       u1_tx_valid,
  output logic [7:0] u1_tx_data,
  input  logic       u1_tx_ready,
  input  logic       i2c_rx_valid,
  input  logic [7:0] i2c_rx_data,
  output logic       i2c_rx_ready,
  output logic       i2c_tx_valid,
  output logic [7:0] i2c_tx_data,
  input  logic       i2c_tx_ready,
  output logic       bl_in_valid,
  output logic [7:0] bl_in_data,
  input  logic       bl_in_ready,
  input  logic       bl_out_valid,
  input  logic [7:0] bl_out_data,
  output logic       bl_out_ready,
  input  logic       bl_busy,
  output logic       bl_reset,
  output logic [1:0] sel
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  sel_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bl_reset_q, bl_reset_d;
  logic             oe_q, oe_d;

  logic       skid_in_ready;
  logic       src_valid, src_break, src_beat;
  logic [7:0] src_data;
  logic       u0_magic, u1_magic, timeout_fire, state_chg;

  // Unselected UARTs are drained so their magic detector keeps seeing bytes.
  always_comb begin
    u0_rx_ready  = (state_q == SEL_U0)  ? skid_in_ready : 1'b1;
    u1_rx_ready  = (state_q == SEL_U1)  ? skid_in_ready : 1'b1;
    i2c_rx_ready = (state_q == SEL_I2C) ? skid_in_ready : 1'b0;
  end

  always_comb begin
    src_valid = 1'b0;
    src_data  = 8'h00;
    src_break = 1'b0;
    case (state_q)
      SEL_I2C: begin src_valid = i2c_rx_valid; src_data = i2c_rx_data; end
      SEL_U0:  begin src_valid = u0_rx_valid;  src_data = u0_rx_data;  src_break = u0_rx_break; end
      SEL_U1:  begin src_valid = u1_rx_valid;  src_data = u1_rx_data;  src_break = u1_rx_break; end
      default: ;
    endcase
  end

  assign src_beat = src_valid && skid_in_ready;

  always_comb begin
    u0_magic     = u0_rx_valid && u0_rx_ready && (u0_rx_data == MAGIC_BYTE) && (state_q != SEL_U0);
    u1_magic     = u1_rx_valid && u1_rx_ready && (u1_rx_data == MAGIC_BYTE) && (state_q == SEL_I2C);
    timeout_fire = (TIMEOUT_CYCLES != 0) && (state_q != SEL_I2C) && !src_beat && !bl_busy &&
                   (cnt_q == CNT_LAST);

    // u0 takes precedence over u1, and a lock-in takes precedence over a coincident timeout.
    state_d = state_q;
    if (u0_magic)          state_d = SEL_U0;
    else if (u1_magic)     state_d = SEL_U1;
    else if (timeout_fire) state_d = SEL_I2C;
    state_chg = (state_d != state_q);

    cnt_d = '0;
    if (state_q != SEL_I2C && !state_chg && !src_beat && !bl_busy)
      cnt_d = cnt_q + 1'b1;

    bl_reset_d = state_chg || src_break;
    oe_d       = oe_q || (state_d == SEL_U0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= SEL_I2C;
      cnt_q      <= '0;
      bl_reset_q <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bl_reset_q <= bl_reset_d;
      oe_q       <= oe_d;
    end
  end

  // A state change flushes the stage, which also discards a byte the old source offers that cycle.
  byte_skid_reg u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (state_chg),
    .in_valid  (src_valid),
    .in_data   (src_data),
    .in_ready  (skid_in_ready),
    .out_valid (bl_in_valid),
    .out_data  (bl_in_data),
    .out_ready (bl_in_ready)
  );

  always_comb begin
    u0_tx_valid  = bl_out_valid && (state_q == SEL_U0);
    u1_tx_valid  = bl_out_valid && (state_q == SEL_U1);
    i2c_tx_valid = bl_out_valid && (state_q == SEL_I2C);
    u0_tx_data   = bl_out_data;
    u1_tx_data   = bl_out_data;
    i2c_tx_data  = bl_out_data;
    case (state_q)
      SEL_U0:  bl_out_ready = u0_tx_ready;
      SEL_U1:  bl_out_ready = u1_tx_ready;
      default: bl_out_ready = i2c_tx_ready;
    endcase
  end

  assign sel      = state_q;
  assign bl_reset = bl_reset_q;
  assign u0_tx_oe = oe_q;

endmodule

// File: tb/tb_boot_port_router.sv
// Self-checking bench for boot_port_router: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the routing rules.
module tb_boot_port_router;

  localparam logic [7:0] MAGIC = 8'hbc;
  localparam int         T     = 100;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       u0_rx_valid, u0_rx_ready, u0_rx_break, u0_tx_valid, u0_tx_ready, u0_tx_oe;
  logic [7:0] u0_rx_data, u0_tx_data;
  logic       u1_rx_valid, u1_rx_ready, u1_rx_break, u1_tx_valid, u1_tx_ready;
  logic [7:0] u1_rx_data, u1_tx_data;
  logic       i2c_rx_valid, i2c_rx_ready, i2c_tx_valid, i2c_tx_ready;
  logic [7:0] i2c_rx_data, i2c_tx_data;
  logic       bl_in_valid, bl_in_ready, bl_out_valid, bl_out_ready, bl_busy, bl_reset;
  logic [7:0] bl_in_data, bl_out_data;
  logic [1:0] sel;

  int tests = 0;
  int fails = 0;

  // Model: active source, one-byte holding slot, idle-cycle count, pulse and pad-enable flags.
  int         m_sel;
  bit         m_full;
  logic [7:0] m_byte;
  int         m_idle;
  bit         m_pulse;
  bit         m_oe;
  int         pulses_seen;

  always #5 clk = ~clk;

  boot_port_router #(.MAGIC_BYTE(MAGIC), .TIMEOUT_CYCLES(T), .CNT_W(24)) dut (
    .clk(clk), .reset_n(reset_n),
    .u0_rx_valid(u0_rx_valid), .u0_rx_data(u0_rx_data), .u0_rx_ready(u0_rx_ready),
    .u0_rx_break(u0_rx_break), .u0_tx_valid(u0_tx_valid), .u0_tx_data(u0_tx_data),
    .u0_tx_ready(u0_tx_ready), .u0_tx_oe(u0_tx_oe),
    .u1_rx_valid(u1_rx_valid), .u1_rx_data(u1_rx_data), .u1_rx_ready(u1_rx_ready),
    .u1_rx_break(u1_rx_break), .u1_tx_valid(u1_tx_valid), .u1_tx_data(u1_tx_data),
    .u1_tx_ready(u1_tx_ready),
    .i2c_rx_valid(i2c_rx_valid), .i2c_rx_data(i2c_rx_data), .i2c_rx_ready(i2c_rx_ready),
    .i2c_tx_valid(i2c_tx_valid), .i2c_tx_data(i2c_tx_data), .i2c_tx_ready(i2c_tx_ready),
    .bl_in_valid(bl_in_valid), .bl_in_data(bl_in_data), .bl_in_ready(bl_in_ready),
    .bl_out_valid(bl_out_valid), .bl_out_data(bl_out_data), .bl_out_ready(bl_out_ready),
    .bl_busy(bl_busy), .bl_reset(bl_reset), .sel(sel)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sel = 0; m_full = 0; m_byte = 8'h00; m_idle = 0; m_pulse = 0; m_oe = 0;
  endtask

  task automatic set_idle();
    u0_rx_valid = 0; u0_rx_data = 8'h00; u0_rx_break = 0; u0_tx_ready = 1;
    u1_rx_valid = 0; u1_rx_data = 8'h00; u1_rx_break = 0; u1_tx_ready = 1;
    i2c_rx_valid = 0; i2c_rx_data = 8'h00; i2c_tx_ready = 1;
    bl_in_ready = 1; bl_out_valid = 0; bl_out_data = 8'h00; bl_busy = 0;
  endtask

  task automatic check_outputs();
    bit srdy;
    srdy = !m_full || bl_in_ready;
    chk("sel", {6'd0, sel}, 8'(m_sel));
    chk("bl_in_valid", bl_in_valid, m_full);
    if (m_full) chk("bl_in_data", bl_in_data, m_byte);
    chk("bl_reset", bl_reset, m_pulse);
    chk("u0_tx_oe", u0_tx_oe, m_oe);
    chk("u0_rx_ready", u0_rx_ready, (m_sel == 1) ? srdy : 1'b1);
    chk("u1_rx_ready", u1_rx_ready, (m_sel == 2) ? srdy : 1'b1);
    chk("i2c_rx_ready", i2c_rx_ready, (m_sel == 0) ? srdy : 1'b0);
    chk("u0_tx_valid", u0_tx_valid, bl_out_valid && m_sel == 1);
    chk("u1_tx_valid", u1_tx_valid, bl_out_valid && m_sel == 2);
    chk("i2c_tx_valid", i2c_tx_valid, bl_out_valid && m_sel == 0);
    chk("bl_out_ready", bl_out_ready, (m_sel == 1) ? u0_tx_ready : (m_sel == 2) ? u1_tx_ready : i2c_tx_ready);
    if (bl_out_valid && m_sel == 0) chk("i2c_tx_data", i2c_tx_data, bl_out_data);
    if (bl_out_valid && m_sel == 1) chk("u0_tx_data", u0_tx_data, bl_out_data);
    if (bl_out_valid && m_sel == 2) chk("u1_tx_data", u1_tx_data, bl_out_data);
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_update();
    bit srdy, r0, r1, ri, b0, b1, bi, sbeat, brk;
    logic [7:0] sdata;
    int nsel;
    if (!reset_n) begin
      model_reset();
      return;
    end
    srdy = !m_full || bl_in_ready;
    r0 = (m_sel == 1) ? srdy : 1'b1;
    r1 = (m_sel == 2) ? srdy : 1'b1;
    ri = (m_sel == 0) ? srdy : 1'b0;
    b0 = u0_rx_valid && r0;
    b1 = u1_rx_valid && r1;
    bi = i2c_rx_valid && ri;
    if (m_sel == 1)      begin sbeat = b0; sdata = u0_rx_data;  brk = u0_rx_break; end
    else if (m_sel == 2) begin sbeat = b1; sdata = u1_rx_data;  brk = u1_rx_break; end
    else                 begin sbeat = bi; sdata = i2c_rx_data; brk = 1'b0; end
    nsel = m_sel;
    if (b0 && u0_rx_data == MAGIC && m_sel != 1)      nsel = 1;
    else if (b1 && u1_rx_data == MAGIC && m_sel == 0) nsel = 2;
    if (m_sel != 0 && nsel == m_sel) begin
      if (sbeat || bl_busy) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle == T) nsel = 0;
      end
    end
    m_pulse = (nsel != m_sel) || brk;
    if (nsel != m_sel) begin
      m_full = 0;
      m_idle = 0;
    end else begin
      if (m_full && bl_in_ready) m_full = 0;
      if (sbeat) begin m_full = 1; m_byte = sdata; end
    end
    if (nsel == 1) m_oe = 1;
    m_sel = nsel;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    if (bl_reset === 1'b1) pulses_seen++;
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    set_idle();
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    reset_n = 1'b0;
    set_idle();
    model_reset();
    pulses_seen = 0;
    #3;
    check_outputs();
    chk("reset_bl_in_data", bl_in_data, 8'h00);
    cycle(); cycle();
    reset_n = 1'b1;
    idle_cycles(2);

    // I2C default path: two bytes, latency 1, no bootloader reset.
    pulses_seen = 0;
    i2c_rx_valid = 1; i2c_rx_data = 8'h11; cycle();
    i2c_rx_data = 8'h22; cycle();
    idle_cycles(2);
    chk("i2c_no_pulse", 8'(pulses_seen), 8'd0);

    // UART1 lock-in, magic consumed, then data forwarded; I2C blocked.
    pulses_seen = 0;
    u1_rx_valid = 1; u1_rx_data = MAGIC; cycle();
    u1_rx_data = 8'h05; i2c_rx_valid = 1; i2c_rx_data = 8'h44; cycle();
    idle_cycles(3);
    chk("u1_lock_sel", {6'd0, sel}, 8'd2);
    chk("u1_lock_pulses", 8'(pulses_seen), 8'd1);

    // UART0 preempts UART1 while a u1 byte is pending; TX follows to u0 only.
    pulses_seen = 0;
    bl_in_ready = 0; u1_rx_valid = 1; u1_rx_data = 8'h33; cycle();
    u1_rx_valid = 0; u0_rx_valid = 1; u0_rx_data = MAGIC; cycle();
    set_idle(); bl_out_valid = 1; bl_out_data = 8'h79; cycle(); cycle();
    idle_cycles(2);
    chk("u0_preempt_sel", {6'd0, sel}, 8'd1);
    chk("u0_preempt_oe", u0_tx_oe, 1'b1);
    chk("u0_preempt_pulses", 8'(pulses_seen), 8'd1);

    // Idle timeout back to I2C; pad enable stays on.
    idle_cycles(T + 3);
    chk("timeout_sel", {6'd0, sel}, 8'd0);
    chk("timeout_oe", u0_tx_oe, 1'b1);

    // Simultaneous magic on both UARTs from I2C: u0 wins with a single pulse.
    pulses_seen = 0;
    u0_rx_valid = 1; u0_rx_data = MAGIC; u1_rx_valid = 1; u1_rx_data = MAGIC; cycle();
    idle_cycles(3);
    chk("tie_sel", {6'd0, sel}, 8'd1);
    chk("tie_pulses", 8'(pulses_seen), 8'd1);

    // Breaks: selected UART pulses, unselected is ignored.
    pulses_seen = 0;
    u0_rx_break = 1; cycle();
    idle_cycles(2);
    chk("u0_break_pulses", 8'(pulses_seen), 8'd1);
    pulses_seen = 0;
    u1_rx_break = 1; cycle();
    idle_cycles(2);
    chk("u1_break_pulses", 8'(pulses_seen), 8'd0);
    chk("break_sel", {6'd0, sel}, 8'd1);

    // Busy bootloader holds off the timeout.
    set_idle(); bl_busy = 1;
    for (int i = 0; i < T + 50; i++) cycle();
    chk("busy_sel", {6'd0, sel}, 8'd1);

    // Random traffic with an asynchronous reset mid-run.
    for (int n = 0; n < 1500; n++) begin
      u0_rx_valid  = ($urandom_range(0, 2) == 0);
      u0_rx_data   = ($urandom_range(0, 11) == 0) ? MAGIC : 8'($urandom);
      u0_rx_break  = ($urandom_range(0, 59) == 0);
      u1_rx_valid  = ($urandom_range(0, 2) == 0);
      u1_rx_data   = ($urandom_range(0, 11) == 0) ? MAGIC : 8'($urandom);
      u1_rx_break  = ($urandom_range(0, 59) == 0);
      i2c_rx_valid = ($urandom_range(0, 1) == 0);
      i2c_rx_data  = 8'($urandom);
      bl_in_ready  = ($urandom_range(0, 3) != 0);
      bl_busy      = ($urandom_range(0, 9) == 0);
      bl_out_valid = ($urandom_range(0, 1) == 0);
      bl_out_data  = 8'($urandom);
      u0_tx_ready  = 1'($urandom);
      u1_tx_ready  = 1'($urandom);
      i2c_tx_ready = 1'($urandom);
      if (n == 700) begin
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        cycle(); cycle();
        reset_n = 1'b1;
      end
      cycle();
    end

    idle_cycles(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
